// File: rtl/lag_counter.sv
// ============================================================================
// lag_counter : start-to-photosensor latency timer with packed BCD result
// Rev 1.0
// ============================================================================
`default_nettype none

module lag_counter #(
  parameter int TICK_CYCLES        = 74,
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int SENSOR_ACTIVE_HIGH = 1,
  parameter int DIGITS             = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  starttrigger,
  input  logic                  sensor,
  output logic [4*DIGITS-1:0]   bcdcount,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  timeout
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic          c_active_lvl = (SENSOR_ACTIVE_HIGH != 0);
  localparam logic [BW-1:0] c_max_count  = {DIGITS{4'h9}};
  localparam logic [PW-1:0] c_pre_last   = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] c_deb_full   = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] c_deb_last   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [DW-1:0]   deb_q, deb_d;
  logic            det_q, det_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic            tmo_q, tmo_d;
  logic            w_active;
  logic            w_tick;

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Debounce counter saturates, so a held-active sensor yields exactly one det.
  assign w_active = (sync2_q == c_active_lvl);

  always_comb begin
    deb_d = deb_q;
    if (!w_active) begin
      deb_d = '0;
    end else if (deb_q != c_deb_full) begin
      deb_d = deb_q + DW'(1);
    end
    det_d = w_active && (deb_q == c_deb_last);
  end

  assign w_tick = (pre_q == c_pre_last);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    tmo_d   = tmo_q;
    case (state_q)
      ST_RUN: begin
        if (starttrigger) begin
          pre_d = '0;
          cnt_d = '0;
        end else if (w_tick && (cnt_q == c_max_count)) begin
          state_d = ST_TIMEOUT;
          bcd_d   = c_max_count;
          valid_d = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          pre_d = w_tick ? '0 : pre_q + PW'(1);
          cnt_d = w_tick ? bcd_inc(cnt_q) : cnt_q;
          // The published result includes any tick landing on the det cycle.
          if (det_q) begin
            state_d = ST_DONE;
            bcd_d   = cnt_d;
            valid_d = 1'b1;
            tmo_d   = 1'b0;
          end
        end
      end
      default: begin
        if (starttrigger) begin
          state_d = ST_RUN;
          pre_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sync1_q <= ~c_active_lvl;
      sync2_q <= ~c_active_lvl;
      deb_q   <= '0;
      det_q   <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sensor;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      det_q   <= det_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bcdcount     = bcd_q;
  assign result_valid = valid_q;
  assign timeout      = tmo_q;
  assign busy         = (state_q == ST_RUN);

endmodule

`default_nettype wire
